// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel programmable clock/tick generator:
// channel-select width helper, reset defaults and the per-channel config record.
package clock_div_pkg;

    localparam int RST_DIV   = 999;
    localparam int RST_HIGH  = 500;
    localparam int CFG_MAX_W = 32;

    typedef struct packed {
        logic [CFG_MAX_W-1:0] div;
        logic [CFG_MAX_W-1:0] high;
    } chan_cfg_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int calc_cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: free-running period counter with shadowed divisor/high-time
// that only takes effect at a period boundary, plus registered tick and level outputs.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int W        = 16,
    parameter int DEF_DIV  = RST_DIV,
    parameter int DEF_HIGH = RST_HIGH
) (
    input  logic      clk_in,
    input  logic      reset,
    input  logic      en,
    input  logic      sync_all,
    input  logic      wr,
    input  chan_cfg_t cfg,
    output logic      cfg_pending,
    output logic      clk_out,
    output logic      tick
);

    logic [W-1:0] count_r, act_div_r, act_high_r, shd_div_r, shd_high_r;
    logic [W-1:0] new_div_s, new_high_s, d_s, nxt_count_s, nxt_act_div_s, nxt_act_high_s;
    logic         wrap_s;

    // A divisor of zero behaves like one so the period never drops below two cycles.
    function automatic logic [W-1:0] eff_div(input logic [W-1:0] v);
        return (v == {W{1'b0}}) ? W'(1) : v;
    endfunction

    assign new_div_s  = cfg.div[W-1:0];
    assign new_high_s = cfg.high[W-1:0];

    if (W < CFG_MAX_W) begin : g_pad
        logic unused_pad_s;
        assign unused_pad_s = ^{cfg.div[CFG_MAX_W-1:W], cfg.high[CFG_MAX_W-1:W]};
    end

    // Next-state: wrap/apply decision, immediate apply while disabled, next count.
    always_comb begin
        d_s            = eff_div(act_div_r);
        wrap_s         = en && (sync_all || (count_r == d_s));
        nxt_act_div_s  = act_div_r;
        nxt_act_high_s = act_high_r;
        if (wrap_s) begin
            nxt_act_div_s  = shd_div_r;
            nxt_act_high_s = shd_high_r;
        end else if (!en && wr) begin
            nxt_act_div_s  = new_div_s;
            nxt_act_high_s = new_high_s;
        end else begin
            nxt_act_div_s  = act_div_r;
            nxt_act_high_s = act_high_r;
        end
        // Parking a disabled channel at its wrap point makes re-enable tick at once.
        if (!en) begin
            nxt_count_s = eff_div(nxt_act_div_s);
        end else if (wrap_s) begin
            nxt_count_s = {W{1'b0}};
        end else begin
            nxt_count_s = count_r + W'(1);
        end
    end

    // Channel state and registered outputs aligned to the newly loaded count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_r     <= W'(DEF_DIV);
            act_div_r   <= W'(DEF_DIV);
            shd_div_r   <= W'(DEF_DIV);
            act_high_r  <= W'(DEF_HIGH);
            shd_high_r  <= W'(DEF_HIGH);
            cfg_pending <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
        end else begin
            count_r    <= nxt_count_s;
            act_div_r  <= nxt_act_div_s;
            act_high_r <= nxt_act_high_s;
            if (wr) begin
                shd_div_r   <= new_div_s;
                shd_high_r  <= new_high_s;
                cfg_pending <= en;
            end else if (wrap_s) begin
                cfg_pending <= 1'b0;
            end else begin
                cfg_pending <= cfg_pending;
            end
            clk_out <= en && (nxt_count_s < nxt_act_high_s);
            tick    <= en && (nxt_count_s == {W{1'b0}});
        end
    end

endmodule

// File: rtl/clock_div_multi.sv
// NCH-channel programmable clock/tick generator: decodes the config channel select
// into per-channel write strobes and replicates the divider channel.
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int W        = 16,
    parameter int DEF_DIV  = RST_DIV,
    parameter int DEF_HIGH = RST_HIGH
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NCH-1:0]          en,
    input  logic                    sync_all,
    input  logic                    cfg_wr,
    input  logic [calc_cw(NCH)-1:0] cfg_ch,
    input  logic [W-1:0]            cfg_div,
    input  logic [W-1:0]            cfg_high,
    output logic [NCH-1:0]          cfg_pending,
    output logic [NCH-1:0]          clk_out,
    output logic [NCH-1:0]          tick
);

    localparam int CW = calc_cw(NCH);

    chan_cfg_t      cfg_s;
    logic [NCH-1:0] wr_s;

    // Select codes at or above NCH match no channel, so such writes are dropped.
    always_comb begin
        cfg_s.div  = CFG_MAX_W'(cfg_div);
        cfg_s.high = CFG_MAX_W'(cfg_high);
        for (int i = 0; i < NCH; i++) begin
            wr_s[i] = cfg_wr && (cfg_ch == CW'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clock_div_chan #(
            .W        (W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk_in      (clk_in),
            .reset       (reset),
            .en          (en[g]),
            .sync_all    (sync_all),
            .wr          (wr_s[g]),
            .cfg         (cfg_s),
            .cfg_pending (cfg_pending[g]),
            .clk_out     (clk_out[g]),
            .tick        (tick[g])
        );
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench: a 2-channel and a 3-channel instance checked every cycle
// against a period/phase model, with directed scenarios and randomized traffic.
module tb_clock_div_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] en3;
    logic       sync_all;
    logic       cfg_wr;
    logic [1:0] cfg_ch2;
    logic [7:0] cfg_div, cfg_high;
    logic [1:0] pend0, clk0, tick0;
    logic [2:0] pend1, clk1, tick1;

    always #5 clk = ~clk;

    clock_div_multi #(.NCH(2), .W(8), .DEF_DIV(3), .DEF_HIGH(2)) dut0 (
        .clk_in(clk), .reset(reset), .en(en3[1:0]), .sync_all(sync_all),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch2[0:0]), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .cfg_pending(pend0), .clk_out(clk0), .tick(tick0)
    );

    clock_div_multi #(.NCH(3), .W(8), .DEF_DIV(3), .DEF_HIGH(2)) dut1 (
        .clk_in(clk), .reset(reset), .en(en3), .sync_all(sync_all),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch2), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .cfg_pending(pend1), .clk_out(clk1), .tick(tick1)
    );

    // Model: position within the current period plus active and shadow settings.
    int m_pos [2][3];
    int m_adiv[2][3], m_ahigh[2][3], m_sdiv[2][3], m_shigh[2][3];
    bit m_clk [2][3], m_tick[2][3], m_pend[2][3];

    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic check(input string name, input int k, input int c, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d ch%0d: got %b expected %b at %0t", name, k, c, act, exp, $time);
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nch = (k == 0) ? 2 : 3;
            int sel = (k == 0) ? int'(cfg_ch2[0]) : int'(cfg_ch2);
            for (int c = 0; c < nch; c++) begin
                bit on = en3[c];
                bit wr = cfg_wr && (sel == c);
                if (reset) begin
                    m_pos[k][c] = 3; m_adiv[k][c] = 3; m_sdiv[k][c] = 3;
                    m_ahigh[k][c] = 2; m_shigh[k][c] = 2;
                    m_clk[k][c] = 0; m_tick[k][c] = 0; m_pend[k][c] = 0;
                end else if (!on) begin
                    if (wr) begin
                        m_adiv[k][c] = cfg_div;  m_sdiv[k][c] = cfg_div;
                        m_ahigh[k][c] = cfg_high; m_shigh[k][c] = cfg_high;
                        m_pend[k][c] = 0;
                    end
                    m_pos[k][c] = eff(m_adiv[k][c]);
                    m_clk[k][c] = 0; m_tick[k][c] = 0;
                end else begin
                    if (sync_all || m_pos[k][c] == eff(m_adiv[k][c])) begin
                        m_pos[k][c] = 0;
                        m_adiv[k][c] = m_sdiv[k][c]; m_ahigh[k][c] = m_shigh[k][c];
                        m_pend[k][c] = 0;
                    end else begin
                        m_pos[k][c] = m_pos[k][c] + 1;
                    end
                    if (wr) begin
                        m_sdiv[k][c] = cfg_div; m_shigh[k][c] = cfg_high; m_pend[k][c] = 1;
                    end
                    m_tick[k][c] = (m_pos[k][c] == 0);
                    m_clk[k][c]  = (m_pos[k][c] < m_ahigh[k][c]);
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Single compare process: every output of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic [2:0] a_clk, a_tick, a_pend;
                a_clk  = (k == 0) ? {1'b0, clk0}  : clk1;
                a_tick = (k == 0) ? {1'b0, tick0} : tick1;
                a_pend = (k == 0) ? {1'b0, pend0} : pend1;
                for (int c = 0; c < ((k == 0) ? 2 : 3); c++) begin
                    check("clk_out", k, c, a_clk[c], m_clk[k][c]);
                    check("tick", k, c, a_tick[c], m_tick[k][c]);
                    check("cfg_pending", k, c, a_pend[c], m_pend[k][c]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic write(input int ch, input int dv, input int hi);
        cfg_wr = 1'b1; cfg_ch2 = 2'(ch); cfg_div = 8'(dv); cfg_high = 8'(hi);
        step(1);
        cfg_wr = 1'b0;
    endtask

    initial begin
        logic [8:0] exp_tick, exp_clk;
        logic [9:0] exp_t2, exp_p2;
        bit found;
        reset = 1'b1; en3 = 3'b001; sync_all = 1'b0; cfg_wr = 1'b0;
        cfg_ch2 = 2'd0; cfg_div = 8'd0; cfg_high = 8'd0;
        step(2);
        chk_on = 1'b1;
        check("reset_clk", 0, 0, clk0[0], 1'b0);
        check("reset_tick", 0, 0, tick0[0], 1'b0);
        check("reset_pend", 1, 2, pend1[2], 1'b0);

        // Default divisor 3, high 2: ticks on edges 1,5,9; level 1,1,0,0.
        exp_tick = 9'b100010001;
        exp_clk  = 9'b100110011;
        reset = 1'b0;
        for (int e = 0; e < 9; e++) begin
            step(1);
            check("pin_tick", 0, 0, tick0[0], exp_tick[e]);
            check("pin_clk", 0, 0, clk0[0], exp_clk[e]);
            check("pin_model_tick", 0, 0, m_tick[0][0], exp_tick[e]);
            check("ch1_idle", 0, 1, clk0[1] | tick0[1], 1'b0);
        end

        // Mid-period write: old period finishes, then 6-cycle periods, level 1,0,0,0,0,0.
        write(0, 5, 1);
        check("pend_after_wr", 0, 0, pend0[0], 1'b1);
        exp_t2 = 10'b0100000100;
        exp_p2 = 10'b0000000011;
        for (int e = 0; e < 10; e++) begin
            step(1);
            check("pin_new_tick", 0, 0, tick0[0], exp_t2[e]);
            check("pin_new_clk", 0, 0, clk0[0], exp_t2[e]);
            check("pin_new_pend", 0, 0, pend0[0], exp_p2[e]);
        end

        // Disabled channel takes config at once; div 0 gives a 2-cycle period.
        write(1, 0, 0);
        check("pend_disabled_wr", 0, 1, pend0[1], 1'b0);
        en3 = 3'b011;
        step(1);
        check("reenable_tick", 0, 1, tick0[1], 1'b1);
        step(7);

        // High-time beyond the divisor holds the level high.
        write(0, 3, 9);
        step(16);

        // Different phases, then sync_all aligns both channels.
        write(1, 3, 2);
        step(5);
        sync_all = 1'b1;
        step(1);
        sync_all = 1'b0;
        check("sync_tick0", 0, 0, tick0[0], 1'b1);
        check("sync_tick1", 0, 1, tick0[1], 1'b1);
        step(12);

        // Write on the exact wrap edge: stays pending for one more period.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_pos[0][0] == eff(m_adiv[0][0])) found = 1'b1;
            else step(1);
        end
        if (!found) check("wrap_wait_timeout", 0, 0, 1'b0, 1'b1);
        write(0, 2, 1);
        check("wrap_wr_tick", 0, 0, tick0[0], 1'b1);
        check("wrap_wr_pend", 0, 0, pend0[0], 1'b1);
        step(8);

        // Select code 3: out of range for the 3-channel instance.
        write(3, 1, 1);
        check("ch3_ignored", 1, 2, pend1[2], 1'b0);
        step(6);

        // Reset in mid-period.
        step(2);
        reset = 1'b1;
        step(1);
        check("midreset_clk0", 0, 0, clk0[0] | clk0[1], 1'b0);
        check("midreset_pend1", 1, 0, |pend1, 1'b0);
        reset = 1'b0;
        step(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom % 200) == 0;
            for (int b = 0; b < 3; b++) if (($urandom % 20) == 0) en3[b] = ~en3[b];
            sync_all = ($urandom % 40) == 0;
            cfg_wr   = ($urandom % 8) == 0;
            cfg_ch2  = 2'($urandom % 4);
            cfg_div  = 8'($urandom % 8);
            cfg_high = 8'($urandom % 10);
            step(1);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- NCH-channel programmable clock/tick generator; successor to the fixed 50%-duty divider.
- Each channel has a runtime divisor and high-time, an enable, a one-cycle tick strobe and a level output.
- Config writes are glitch-free: they go to a shadow register and are applied only at a period boundary.
- Sits next to the board clock and feeds game timers, display multiplexing and debounce strobes from the 100 MHz clk_in.

Parameters:
- NCH, 4: number of channels (1..16).
- W, 16: width of the divisor/high-time counter.
- DEF_DIV, 999: reset divisor; period is DEF_DIV+1 cycles.
- DEF_HIGH, 500: reset high-time in cycles.

Ports:
- clk_in  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel enable.
- sync_all  in  1  phase-align all enabled channels.
- cfg_wr  in  1  config write strobe, one cycle.
- cfg_ch  in  CW=max(1,clog2(NCH))  target channel.
- cfg_div  in  W  new divisor.
- cfg_high  in  W  new high-time.
- cfg_pending  out  NCH  shadow written but not yet applied.
- clk_out  out  NCH  divided level output, registered.
- tick  out  NCH  one-cycle strobe at period start, registered.

Behaviour:
- Reset values (on the first edge with reset=1): per channel act_div=shd_div=DEF_DIV, act_high=shd_high=DEF_HIGH, count=DEF_DIV; clk_out=0, tick=0, cfg_pending=0. Reset overrides every other input.
- Effective divisor: d = max(act_div,1). A value of 0 is treated as 1, giving a minimum period of 2 cycles.
- Enabled channel, each edge:
  - If count==d (wrap): count<=0, act_div<=shd_div, act_high<=shd_high, cfg_pending[ch]<=0.
  - Otherwise: count<=count+1.
- Outputs are registered and aligned to the count just loaded:
  - tick<=(next_count==0).
  - clk_out<=(next_count < next_high), where next_high is the high-time in force after the edge.
  - High-time 0 gives clk_out constantly 0. High-time > d gives clk_out constantly 1 (tick still pulses).
- Because count resets to DEF_DIV, the first enabled edge after reset wraps: tick=1, clk_out=(DEF_HIGH>0).
- Disabled channel (en=0):
  - count<=d (act_div after any apply this edge), clk_out<=0, tick<=0.
  - Re-enable starts a fresh period on the first enabled edge (tick on that edge).
- Config write (cfg_wr=1, cfg_ch<NCH):
  - shd_div/shd_high of cfg_ch are written; cfg_pending[cfg_ch]<=1.
  - If that channel is disabled on the same edge, it is applied immediately: act<=new values, pending stays 0.
  - cfg_ch>=NCH: write ignored.
- Write coinciding with a wrap: the wrap applies the previous shadow. The new values stay pending until the next wrap.
- sync_all=1: every enabled channel is forced to wrap on this edge (count<=0, shadow applied, tick=1) regardless of count. Disabled channels are unaffected.
- Channels are independent; apart from sync_all, no cross-channel timing dependency.
- Arithmetic: count is W bits unsigned. The comparison uses d so count never exceeds it. No overflow is possible.

Decomposition:
- Shared package clock_div_pkg:
  - CW computation function.
  - Reset-default constants.
  - Typedef chan_cfg_t {div,high}.
- Sub-module clock_div_chan: one channel's counter, shadow, apply, tick and clk_out logic.
- Top clock_div_multi: decodes cfg_ch into per-channel write strobes and generate-instantiates NCH copies of clock_div_chan.

Test Plan (NCH=2, W=8, DEF_DIV=3, DEF_HIGH=2):
- Reset release with en=2'b01 → ch0:
  - tick pulses on edges 1, 5, 9 after release.
  - clk_out pattern 1,1,0,0 repeating.
  - ch1 outputs stay 0.
- With ch0 running, write cfg_ch=0, div=5, high=1 mid-period:
  - cfg_pending[0]=1 until the next wrap.
  - The current period still runs 4 cycles, then 6-cycle periods with clk_out 1,0,0,0,0,0.
- Write div=0, high=0 to disabled ch1, then enable → applied at once, no pending; period 2, clk_out stays 0, tick every 2nd cycle.
- Write high=9 with div=3 → after the next wrap clk_out constantly 1, tick still every 4 cycles.
- ch0 and ch1 running at different phases, assert sync_all one cycle → both tick on that edge, then tick in lockstep when divisors are equal.
- Cases to cover:
  - Write coinciding exactly with a wrap edge → old shadow applied, new value pending one more period.
  - Reset asserted mid-period → next edge returns all outputs and registers to the reset values.
  - cfg_ch=3 → ignored.
